// File: rtl/mux4_1_casez.sv
// Fixed-priority 4:1 mux (sel[0] highest) with combinational and registered outputs.
// Optional MUX4_1_CASEZ_ONEHOT_CHK_EN adds multi/multi_q flags for overlapping requests.
module mux4_1_casez #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic             hit,
  output logic [1:0]       idx,
  output logic [WIDTH-1:0] dout_q,
  output logic             hit_q,
  output logic [1:0]       idx_q
`ifdef MUX4_1_CASEZ_ONEHOT_CHK_EN
  ,
  output logic             multi,
  output logic             multi_q
`endif
);

  logic [WIDTH-1:0] w_dout;
  logic             w_hit;
  logic [1:0]       w_idx;

  logic [WIDTH-1:0] r_dout_q;
  logic             r_hit_q;
  logic [1:0]       r_idx_q;

  // Lowest set request bit wins; the default arm covers sel == 0.
  always_comb begin
    w_dout = '0;
    w_hit  = 1'b0;
    w_idx  = 2'd0;
    casez (sel)
      4'b???1: begin
        w_dout = a;
        w_hit  = 1'b1;
        w_idx  = 2'd0;
      end
      4'b??10: begin
        w_dout = b;
        w_hit  = 1'b1;
        w_idx  = 2'd1;
      end
      4'b?100: begin
        w_dout = c;
        w_hit  = 1'b1;
        w_idx  = 2'd2;
      end
      4'b1000: begin
        w_dout = d;
        w_hit  = 1'b1;
        w_idx  = 2'd3;
      end
      default: begin
        w_dout = '0;
        w_hit  = 1'b0;
        w_idx  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_q <= '0;
      r_hit_q  <= 1'b0;
      r_idx_q  <= 2'd0;
    end else begin
      r_dout_q <= w_dout;
      r_hit_q  <= w_hit;
      r_idx_q  <= w_idx;
    end
  end

  assign dout   = w_dout;
  assign hit    = w_hit;
  assign idx    = w_idx;
  assign dout_q = r_dout_q;
  assign hit_q  = r_hit_q;
  assign idx_q  = r_idx_q;

`ifdef MUX4_1_CASEZ_ONEHOT_CHK_EN
  logic w_multi;
  logic r_multi_q;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    w_multi = ((sel & (sel - 4'd1)) != 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_multi_q <= 1'b0;
    end else begin
      r_multi_q <= w_multi;
    end
  end

  assign multi   = w_multi;
  assign multi_q = r_multi_q;
`endif

endmodule

// File: tb/tb_mux4_1_casez.sv
// Directed, table-driven bench for mux4_1_casez at WIDTH=8, plus hand-written
// sequences for data tracking, registered latency and asynchronous reset.
module tb_mux4_1_casez;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       sel;
  logic [WIDTH-1:0] dout, dout_q;
  logic             hit, hit_q;
  logic [1:0]       idx, idx_q;
`ifdef MUX4_1_CASEZ_ONEHOT_CHK_EN
  logic             multi, multi_q;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string            name;
    logic [3:0]       sel;
    logic [WIDTH-1:0] a, b, c, d;
    logic [WIDTH-1:0] expDout;
    logic             expHit;
    logic [1:0]       expIdx;
    logic             expMulti;
  } vec_t;

  vec_t vecs[$];

  mux4_1_casez #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .sel    (sel),
    .dout   (dout),
    .hit    (hit),
    .idx    (idx),
    .dout_q (dout_q),
    .hit_q  (hit_q),
    .idx_q  (idx_q)
`ifdef MUX4_1_CASEZ_ONEHOT_CHK_EN
    ,
    .multi  (multi),
    .multi_q(multi_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vc,
                               input logic [WIDTH-1:0] vd);
    sel = s;
    a   = va;
    b   = vb;
    c   = vc;
    d   = vd;
  endtask

  task automatic addVec(input string n, input logic [3:0] s, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vc,
                        input logic [WIDTH-1:0] vd, input logic [WIDTH-1:0] ed,
                        input logic eh, input logic [1:0] ei, input logic em);
    vec_t v;
    v.name = n; v.sel = s; v.a = va; v.b = vb; v.c = vc; v.d = vd;
    v.expDout = ed; v.expHit = eh; v.expIdx = ei; v.expMulti = em;
    vecs.push_back(v);
  endtask

  initial begin
    // Single-hot walk with a=0,b=1,c=0,d=1.
    addVec("s1_0000", 4'b0000, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 2'd0, 1'b0);
    addVec("s1_0001", 4'b0001, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1, 2'd0, 1'b0);
    addVec("s1_0010", 4'b0010, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 1'b1, 2'd1, 1'b0);
    addVec("s1_0100", 4'b0100, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1, 2'd2, 1'b0);
    addVec("s1_1000", 4'b1000, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 1'b1, 2'd3, 1'b0);
    // Overlapping requests with distinct 8-bit sources.
    addVec("s2_0011", 4'b0011, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hA5, 1'b1, 2'd0, 1'b1);
    addVec("s2_0110", 4'b0110, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h3C, 1'b1, 2'd1, 1'b1);
    addVec("s2_1100", 4'b1100, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h0F, 1'b1, 2'd2, 1'b1);
    addVec("s2_1001", 4'b1001, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hA5, 1'b1, 2'd0, 1'b1);
    addVec("x_1111",  4'b1111, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hA5, 1'b1, 2'd0, 1'b1);
    addVec("x_1110",  4'b1110, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h3C, 1'b1, 2'd1, 1'b1);
    addVec("x_1000",  4'b1000, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hF0, 1'b1, 2'd3, 1'b0);
    addVec("x_0000",  4'b0000, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h00, 1'b0, 2'd0, 1'b0);
    addVec("x_1010",  4'b1010, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h3C, 1'b1, 2'd1, 1'b1);
    addVec("x_0101",  4'b0101, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hA5, 1'b1, 2'd0, 1'b1);

    // Reset state, and combinational path alive while reset is held.
    rst = 1'b1;
    applyStimulus(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00);
    #2;
    checkOutput("rst_dout_q", 32'(dout_q), 32'h0);
    checkOutput("rst_hit_q",  32'(hit_q),  32'h0);
    checkOutput("rst_idx_q",  32'(idx_q),  32'h0);
    checkOutput("rst_dout_comb", 32'(dout), 32'h5A);
    checkOutput("rst_hit_comb",  32'(hit),  32'h1);
    @(posedge clk); #1;
    checkOutput("rst_hold_dout_q", 32'(dout_q), 32'h0);
`ifdef MUX4_1_CASEZ_ONEHOT_CHK_EN
    checkOutput("rst_multi_q", 32'(multi_q), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_before_edge", 32'(dout_q), 32'h0);
    @(posedge clk); #1;
    checkOutput("post_rst_load_dout_q", 32'(dout_q), 32'h5A);
    checkOutput("post_rst_load_hit_q",  32'(hit_q),  32'h1);

    // Table: combinational check, then registered check one edge later.
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
      #1;
      checkOutput({vecs[i].name, "_dout"}, 32'(dout), 32'(vecs[i].expDout));
      checkOutput({vecs[i].name, "_hit"},  32'(hit),  32'(vecs[i].expHit));
      checkOutput({vecs[i].name, "_idx"},  32'(idx),  32'(vecs[i].expIdx));
`ifdef MUX4_1_CASEZ_ONEHOT_CHK_EN
      checkOutput({vecs[i].name, "_multi"}, 32'(multi), 32'(vecs[i].expMulti));
`endif
      @(posedge clk); #1;
      checkOutput({vecs[i].name, "_dout_q"}, 32'(dout_q), 32'(vecs[i].expDout));
      checkOutput({vecs[i].name, "_hit_q"},  32'(hit_q),  32'(vecs[i].expHit));
      checkOutput({vecs[i].name, "_idx_q"},  32'(idx_q),  32'(vecs[i].expIdx));
`ifdef MUX4_1_CASEZ_ONEHOT_CHK_EN
      checkOutput({vecs[i].name, "_multi_q"}, 32'(multi_q), 32'(vecs[i].expMulti));
`endif
    end

    // Data tracking: dout follows a with no clock edge in between.
    @(negedge clk);
    applyStimulus(4'b0001, 8'h00, 8'h01, 8'h00, 8'h00);
    #1;
    checkOutput("s3_a0", 32'(dout), 32'h00);
    a = 8'h01;
    #1;
    checkOutput("s3_a1", 32'(dout), 32'h01);
    sel = 4'b0010;
    #1;
    checkOutput("s3_sel_b", 32'(dout), 32'h01);
    checkOutput("s3_idx_b", 32'(idx), 32'd1);

    // Registered path: one edge of latency on assert and on clear.
    @(negedge clk);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    checkOutput("s4_pre_dout_q", 32'(dout_q), 32'h0);
    @(negedge clk);
    applyStimulus(4'b0100, 8'h00, 8'h00, 8'h01, 8'h00);
    #1;
    checkOutput("s4_dout_comb", 32'(dout), 32'h1);
    checkOutput("s4_dout_q_lag", 32'(dout_q), 32'h0);
    @(posedge clk); #1;
    checkOutput("s4_dout_q", 32'(dout_q), 32'h1);
    checkOutput("s4_idx_q",  32'(idx_q),  32'd2);
    @(negedge clk);
    sel = 4'b0000;
    @(posedge clk); #1;
    checkOutput("s4_clr_dout_q", 32'(dout_q), 32'h0);
    checkOutput("s4_clr_hit_q",  32'(hit_q),  32'h0);

    // Asynchronous reset between edges clears registers at once.
    @(negedge clk);
    sel = 4'b0100;
    @(posedge clk); #1;
    checkOutput("s5_pre_dout_q", 32'(dout_q), 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("s5_async_dout_q", 32'(dout_q), 32'h0);
    checkOutput("s5_async_hit_q",  32'(hit_q),  32'h0);
    checkOutput("s5_async_idx_q",  32'(idx_q),  32'h0);
    checkOutput("s5_dout_unaff",   32'(dout),   32'h1);
    checkOutput("s5_idx_unaff",    32'(idx),    32'd2);
    rst = 1'b0;
    #1;
    checkOutput("s5_released_hold", 32'(dout_q), 32'h0);
    @(posedge clk); #1;
    checkOutput("s5_reload_dout_q", 32'(dout_q), 32'h1);
    checkOutput("s5_reload_hit_q",  32'(hit_q),  32'h1);
    checkOutput("s5_reload_idx_q",  32'(idx_q),  32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
